// File: rtl/instr_sequencer_if.sv
// Sequencer bundle: program-load/start controls in, reg_file_alu control and data out.
interface instr_sequencer_if #(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 4,
  parameter int PC_W    = 4
);
  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [23:0]        prog_data;
  logic               start;
  logic               busy;
  logic               done;
  logic [PC_W-1:0]    pc;
  logic [RADDR_W-1:0] RA1;
  logic [RADDR_W-1:0] RA2;
  logic [RADDR_W-1:0] WA;
  logic [DATA_W-1:0]  external_data_in;
  logic               RegWrite;
  logic               ALUSrc;
  logic [1:0]         ALUControl;

  modport master (
    output prog_we, prog_addr, prog_data, start,
    input  busy, done, pc, RA1, RA2, WA, external_data_in, RegWrite, ALUSrc, ALUControl
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start,
    output busy, done, pc, RA1, RA2, WA, external_data_in, RegWrite, ALUSrc, ALUControl
  );
endinterface

// File: rtl/instr_sequencer.sv
// Program sequencer for reg_file_alu: fetch, execute, one-cycle writeback strobe.
module instr_sequencer #(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 4,
  parameter int DEPTH   = 16,
  parameter int PC_W    = 4
) (
  input logic               clk,
  input logic               reset,
  instr_sequencer_if.slave  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] WB    = 2'd3;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_R    = 2'b01;
  localparam logic [1:0] OP_I    = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  logic [1:0]         state;
  logic [1:0]         op_q;
  logic [23:0]        mem [DEPTH];
  logic [23:0]        fetch_word;
  logic [PC_W-1:0]    pc_q;
  logic               done_q;
  logic               regwrite_q;
  logic               alusrc_q;
  logic [1:0]         aluctl_q;
  logic [RADDR_W-1:0] ra1_q, ra2_q, wa_q;
  logic [DATA_W-1:0]  imm_q;

  assign fetch_word = mem[pc_q];

  // Program memory is deliberately left out of reset; loads are only taken while idle.
  always_ff @(posedge clk) begin
    if (bus.prog_we && state == IDLE)
      mem[bus.prog_addr] <= bus.prog_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= OP_NOP;
      pc_q       <= '0;
      done_q     <= 1'b0;
      regwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      aluctl_q   <= '0;
      ra1_q      <= '0;
      ra2_q      <= '0;
      wa_q       <= '0;
      imm_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= FETCH;
            pc_q  <= '0;
          end
        end
        // Operand fields are registered on FETCH exit so they are stable for all of EXEC and WB.
        FETCH: begin
          op_q     <= fetch_word[23:22];
          aluctl_q <= fetch_word[21:20];
          wa_q     <= RADDR_W'(fetch_word[19:16]);
          ra1_q    <= RADDR_W'(fetch_word[15:12]);
          ra2_q    <= RADDR_W'(fetch_word[11:8]);
          imm_q    <= DATA_W'(fetch_word[7:0]);
          alusrc_q <= (fetch_word[23:22] == OP_I);
          state    <= EXEC;
        end
        EXEC: begin
          regwrite_q <= (op_q == OP_R) || (op_q == OP_I);
          state      <= WB;
        end
        WB: begin
          regwrite_q <= 1'b0;
          if (op_q == OP_HALT) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            pc_q  <= pc_q + 1'b1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy             = (state != IDLE);
  assign bus.done             = done_q;
  assign bus.pc               = pc_q;
  assign bus.RA1              = ra1_q;
  assign bus.RA2              = ra2_q;
  assign bus.WA               = wa_q;
  assign bus.external_data_in = imm_q;
  assign bus.RegWrite         = regwrite_q;
  assign bus.ALUSrc           = alusrc_q;
  assign bus.ALUControl       = aluctl_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: per-cycle comparison against an instruction/phase model.
module tb_instr_sequencer;
  localparam int DATA_W  = 8;
  localparam int RADDR_W = 4;
  localparam int DEPTH   = 16;
  localparam int PC_W    = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [23:0] ref_mem [DEPTH];

  instr_sequencer_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .PC_W(PC_W)) bus ();

  instr_sequencer #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input int op, input int func, input int rd,
                                     input int rs1, input int rs2, input int imm);
    return {op[1:0], func[1:0], rd[3:0], rs1[3:0], rs2[3:0], imm[7:0]};
  endfunction

  task automatic write_mem(input int addr, input logic [23:0] data);
    @(posedge clk); #1;
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr[PC_W-1:0];
    bus.prog_data = data;
    @(posedge clk); #1;
    bus.prog_we   = 1'b0;
    ref_mem[addr] = data;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1 reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Cycle n after start belongs to instruction n/3 (address n/3 mod DEPTH), phase n%3:
  // 0 fetch, 1 execute, 2 writeback.  A HALT ends the run after its writeback.
  task automatic run_program(input string tag, input int max_cycles);
    logic [23:0] w;
    logic        exp_rw;
    logic [22:0] exp_fields;
    int k, ph, exp_cnt, obs_cnt;
    bit halted;
    exp_cnt = 0; obs_cnt = 0; halted = 0;
    for (int n = 0; n < max_cycles && !halted; n++) begin
      @(negedge clk);
      k  = n / 3;
      ph = n % 3;
      w  = ref_mem[k % DEPTH];
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.pc !== PC_W'(k % DEPTH)) begin
        errors++;
        $display("FAIL %s status cycle %0d: busy=%b done=%b pc=%0d, required busy=1 done=0 pc=%0d",
                 tag, n, bus.busy, bus.done, bus.pc, k % DEPTH);
      end
      exp_rw = (ph == 2) && (w[23:22] == 2'b01 || w[23:22] == 2'b10);
      checks++;
      if (bus.RegWrite !== exp_rw) begin
        errors++;
        $display("FAIL %s RegWrite cycle %0d: got %b, required %b", tag, n, bus.RegWrite, exp_rw);
      end
      if (ph != 0) begin
        exp_fields = {w[15:12], w[11:8], w[19:16], w[7:0], w[21:20], (w[23:22] == 2'b10)};
        checks++;
        if ({bus.RA1, bus.RA2, bus.WA, bus.external_data_in, bus.ALUControl, bus.ALUSrc} !== exp_fields) begin
          errors++;
          $display("FAIL %s fields cycle %0d: got RA1=%h RA2=%h WA=%h imm=%h ctl=%b src=%b, required word %h",
                   tag, n, bus.RA1, bus.RA2, bus.WA, bus.external_data_in, bus.ALUControl, bus.ALUSrc, w);
        end
      end
      if (bus.RegWrite === 1'b1) obs_cnt++;
      if (exp_rw) exp_cnt++;
      if (ph == 2 && w[23:22] == 2'b11) halted = 1;
    end
    if (halted) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.RegWrite !== 1'b0) begin
        errors++;
        $display("FAIL %s done pulse: done=%b busy=%b RegWrite=%b, required 1 0 0",
                 tag, bus.done, bus.busy, bus.RegWrite);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL %s after done: done=%b busy=%b, required 0 0", tag, bus.done, bus.busy);
      end
    end
    checks++;
    if (obs_cnt != exp_cnt) begin
      errors++;
      $display("FAIL %s RegWrite pulse count: got %0d, required %0d", tag, obs_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.pc, bus.RA1, bus.RA2, bus.WA, bus.external_data_in,
         bus.RegWrite, bus.ALUSrc, bus.ALUControl} !== '0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b pc=%0d RA1=%0d RA2=%0d WA=%0d imm=%h rw=%b src=%b ctl=%b, required all 0",
               bus.busy, bus.done, bus.pc, bus.RA1, bus.RA2, bus.WA, bus.external_data_in,
               bus.RegWrite, bus.ALUSrc, bus.ALUControl);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.RegWrite !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: busy=%b RegWrite=%b, required 0 0", i, bus.busy, bus.RegWrite);
      end
    end
  endtask

  task automatic test_itype();
    write_mem(0, mk(2, 1, 1, 0, 0, 8'h05));
    write_mem(1, mk(3, 0, 0, 0, 0, 0));
    pulse_start();
    run_program("itype", 20);
  endtask

  task automatic test_rtype_chain();
    write_mem(0, mk(2, 0, 4, 0, 0, 4));
    write_mem(1, mk(2, 0, 5, 0, 0, 5));
    write_mem(2, mk(1, 3, 6, 5, 4, 0));
    write_mem(3, mk(3, 0, 0, 0, 0, 0));
    pulse_start();
    run_program("rtype_chain", 30);
  endtask

  task automatic test_nop_wrap();
    for (int a = 0; a < DEPTH; a++) write_mem(a, 24'h0);
    pulse_start();
    run_program("nop_wrap", 3 * DEPTH + 6);
    do_reset(1);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.pc !== '0) begin
      errors++;
      $display("FAIL nop_wrap reset: busy=%b pc=%0d, required 0 0", bus.busy, bus.pc);
    end
  endtask

  task automatic test_busy_ignore();
    write_mem(0, mk(2, 2, 3, 1, 2, 8'h3C));
    write_mem(1, mk(1, 1, 9, 3, 4, 8'h11));
    write_mem(2, mk(3, 0, 0, 0, 0, 0));
    pulse_start();
    fork
      run_program("busy_ignore", 30);
      begin
        @(posedge clk); #1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd1;
        bus.prog_data = mk(2, 1, 7, 7, 7, 8'hAA);
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.prog_we   = 1'b0;
        bus.start     = 1'b0;
      end
    join
    pulse_start();
    run_program("busy_rerun", 30);
  endtask

  task automatic test_reset_in_wb();
    bit seen;
    seen = 0;
    write_mem(0, mk(2, 1, 2, 0, 0, 8'h22));
    write_mem(1, mk(2, 0, 3, 0, 0, 8'h33));
    write_mem(2, mk(1, 2, 4, 2, 3, 0));
    write_mem(3, mk(3, 0, 0, 0, 0, 0));
    pulse_start();
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.RegWrite === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_in_wb wait: RegWrite never rose within 20 cycles, required a writeback");
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.pc, bus.RA1, bus.RA2, bus.WA, bus.external_data_in,
         bus.RegWrite, bus.ALUSrc, bus.ALUControl} !== '0) begin
      errors++;
      $display("FAIL reset_in_wb values: busy=%b done=%b pc=%0d RegWrite=%b WA=%0d, required all 0",
               bus.busy, bus.done, bus.pc, bus.RegWrite, bus.WA);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_wb no_done: done=%b busy=%b, required 0 0", bus.done, bus.busy);
    end
    pulse_start();
    run_program("reset_rerun", 30);
  endtask

  task automatic test_random_programs();
    int h;
    for (int r = 0; r < 4; r++) begin
      h = int'($urandom_range(1, DEPTH - 1));
      for (int a = 0; a < DEPTH; a++) begin
        if (a == h)
          write_mem(a, mk(3, 0, 0, 0, 0, 0));
        else
          write_mem(a, mk(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 255))));
      end
      pulse_start();
      run_program("random", 3 * DEPTH + 6);
    end
  endtask

  initial begin
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.start     = 1'b0;
    test_reset();
    test_itype();
    test_rtype_chain();
    test_nop_wrap();
    test_busy_ignore();
    test_reset_in_wb();
    test_random_programs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Program sequencer that sits directly upstream of reg_file_alu and drives all of its control and data inputs: RA1, RA2, WA, external_data_in, RegWrite, ALUSrc and ALUControl. It holds a small writable program memory, fetches and decodes one instruction at a time, and issues a read/execute phase followed by a one-cycle writeback strobe. This replaces hand-driven testbench stimulus with a self-running instruction stream.

Parameters:
DATA_W, 8, width of external_data_in / immediate field
RADDR_W, 4, register address width (RA1/RA2/WA)
DEPTH, 16, program memory entries (power of two)
PC_W, 4, log2(DEPTH)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; returns FSM and outputs to reset values
prog_we  in  1  program memory write strobe
prog_addr  in  PC_W  program memory write address
prog_data  in  24  instruction word to write
start  in  1  begin execution at PC 0 (one-cycle pulse)
busy  out  1  high from FETCH through WB, inclusive
done  out  1  one-cycle pulse when HALT is retired
pc  out  PC_W  address of the instruction currently in flight
RA1  out  RADDR_W  read address 1 to reg file
RA2  out  RADDR_W  read address 2 to reg file
WA  out  RADDR_W  write address to reg file
external_data_in  out  DATA_W  immediate operand to reg file/ALU
RegWrite  out  1  reg file write enable
ALUSrc  out  1  0 = RA2 operand, 1 = external_data_in
ALUControl  out  2  ALU function select, passed through from instruction

Behaviour:
- Instruction word [23:22] op, [21:20] func, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] imm. op 00 NOP, 01 R-type, 10 I-type, 11 HALT.
- Reset values: FSM=IDLE, pc=0, busy=0, done=0, RA1=RA2=WA=0, external_data_in=0, RegWrite=0, ALUSrc=0, ALUControl=0. Program memory not cleared by reset.
- prog_we writes mem[prog_addr]=prog_data at the clock edge, accepted only in IDLE; ignored while busy.
- States: IDLE, FETCH, EXEC, WB.
- IDLE: start=1 -> FETCH, pc=0. start with prog_we in same cycle: write completes, then fetch.
- FETCH (1 cycle): instruction register <= mem[pc]; busy=1. -> EXEC.
- EXEC (1 cycle): drive RA1=rs1, RA2=rs2, WA=rd, ALUControl=func, external_data_in=imm; ALUSrc=1 for I-type, 0 otherwise; RegWrite=0. -> WB.
- WB (1 cycle): all EXEC outputs held stable; RegWrite=1 only for R-type/I-type, 0 for NOP/HALT.
- WB exit: HALT -> IDLE with done=1 for exactly that following cycle and busy=0; otherwise pc<=pc+1 and -> FETCH.
- pc wraps DEPTH-1 -> 0; no implicit stop. A program without HALT runs forever until reset.
- Throughput: 3 cycles per instruction, exactly one RegWrite pulse per R/I instruction.
- start while busy is ignored.
- RegWrite is never high outside WB, and never high in two consecutive cycles.
- Reset mid-operation, including during WB: next cycle is IDLE with all outputs at reset values. The in-flight write is abandoned. No done pulse.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> busy=0, RegWrite=0, pc=0, all addresses 0; start not asserted -> state stays IDLE.
- I-type load: mem[0]={10,01,0001,0000,0000,0x05}, mem[1]=HALT, start -> WB cycle shows WA=1, ALUSrc=1, external_data_in=5, ALUControl=01, RegWrite=1; done pulses 6 cycles after start; reg_file_alu reg1 holds 5.
- R-type chain: load r4=4, r5=5 via I-type, then {01,11,0110,0101,0100,0}, then HALT -> third WB shows RA1=5, RA2=4, WA=6, ALUSrc=0, ALUControl=11, RegWrite=1; exactly 3 RegWrite pulses total.
- NOP and wrap: fill all 16 entries with NOP -> RegWrite never asserted; pc steps 0..15 then returns to 0; busy stays 1.
- prog_we/start while busy: write mem[1] and pulse start during EXEC of instruction 0 -> memory unchanged, pc sequence unaffected.
- Reset in WB: assert reset while RegWrite=1 -> next cycle RegWrite=0, busy=0, pc=0, no done pulse; subsequent start reruns the program from address 0.
